// File: rtl/run_ctrl_pkg.sv
// Shared types, default parameters and sizing helper for the run-level sequencer.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    RUN,
    DRAIN,
    FIN
  } run_state_t;

  localparam int DEF_CNT_W        = 16;
  localparam int DEF_MAX_CYCLES   = 4096;
  localparam int DEF_RESET_CYCLES = 2;
  localparam int DEF_DRAIN_CYCLES = 1;

  // Counter width able to hold value-1, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/run_timer.sv
// Loadable down-counter with a zero flag; stops at zero until reloaded.
module run_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/run_ctrl.sv
// Run-level sequencer: turns the req/done handshake into core reset/enable,
// counts RUN cycles and ends runaway programs at MAX_CYCLES.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             program_done,
  output logic             core_reset,
  output logic             core_en,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int RST_W = clog2_min1(RESET_CYCLES);
  localparam int DRN_W = clog2_min1(DRAIN_CYCLES);

  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RESET_CYCLES - 1);
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  run_state_t state, next_state;

  logic req_q;
  logic start;
  logic rst_load, rst_zero;
  logic drn_load, drn_zero;
  logic cnt_clear, cnt_inc;
  logic timeout_next;

  // req_q follows req even through reset, so a level held across reset is not a start.
  always_ff @(posedge clk) begin
    req_q <= req;
  end

  assign start = req & ~req_q;

  run_timer #(.W(RST_W)) rst_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (rst_load),
    .load_val (RST_LOAD),
    .dec      (state == RST),
    .zero     (rst_zero)
  );

  run_timer #(.W(DRN_W)) drain_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (drn_load),
    .load_val (DRN_LOAD),
    .dec      (state == DRAIN),
    .zero     (drn_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state   = state;
    rst_load     = 1'b0;
    drn_load     = 1'b0;
    cnt_clear    = 1'b0;
    cnt_inc      = 1'b0;
    timeout_next = timeout;
    case (state)
      IDLE, FIN: begin
        if (start) begin
          next_state   = RST;
          rst_load     = 1'b1;
          cnt_clear    = 1'b1;
          timeout_next = 1'b0;
        end
      end
      RST: begin
        if (rst_zero) next_state = RUN;
      end
      RUN: begin
        cnt_inc = 1'b1;
        if (program_done) begin
          timeout_next = 1'b0;
          if (DRAIN_CYCLES == 0) begin
            next_state = FIN;
          end else begin
            next_state = DRAIN;
            drn_load   = 1'b1;
          end
        end else if (cycle_count == LIMIT) begin
          next_state   = FIN;
          timeout_next = 1'b1;
        end
      end
      DRAIN: begin
        if (drn_zero) next_state = FIN;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_reset  <= 1'b1;
      core_en     <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      core_reset <= (next_state == IDLE) || (next_state == RST);
      core_en    <= (next_state == RUN);
      done       <= (next_state == FIN);
      timeout    <= timeout_next;
      if (cnt_clear) begin
        cycle_count <= '0;
      end else if (cnt_inc && cycle_count != CNT_SAT) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
    end
  end

endmodule
